// File: rtl/vram_pkg.sv
// Shared definitions for the display RAM arbiter: read-return owner encoding
// and default memory geometry.
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;
  localparam int VRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SCAN = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and memory-port bundle for the display RAM arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = vram_pkg::VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = vram_pkg::VRAM_DATA_WIDTH
);

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic                  scan_req;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  scan_ack;
  logic                  scan_rvalid;
  logic [DATA_WIDTH-1:0] scan_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rvalid, host_rdata,
    input  scan_req, scan_addr,
    output scan_ack, scan_rvalid, scan_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rvalid, host_rdata,
    output scan_req, scan_addr,
    input  scan_ack, scan_rvalid, scan_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_starve_timer.sv
// Saturating count of consecutive cycles the host has been denied; starved
// tells the grant logic to let the host win over scan-out.
module arb_starve_timer #(
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             host_req,
  input  logic             host_grant,
  output logic [CNT_W-1:0] starve_cnt,
  output logic             starved
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!host_req || host_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign starved = (starve_cnt == LIMIT);

endmodule

// File: rtl/vram_arbiter.sv
// Fixed-priority arbiter for the single-port display RAM: scan-out wins unless
// the host has been starved; read data is routed back to whoever issued it.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clock,
  input logic         reset,
  vram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                  grant_scan;
  logic                  grant_host;
  logic                  starved;
  logic [CNT_W-1:0]      starve_cnt;
  logic [ADDR_WIDTH-1:0] grant_addr;
  owner_t                owner_d;
  owner_t                owner_q;
  logic [DATA_WIDTH-1:0] scan_hold_q;
  logic [DATA_WIDTH-1:0] host_hold_q;

  arb_starve_timer #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .host_req   (bus.host_req),
    .host_grant (grant_host),
    .starve_cnt (starve_cnt),
    .starved    (starved)
  );

  // Gated by reset so every port output reads 0 the moment reset is raised.
  always_comb begin
    grant_scan = 1'b0;
    grant_host = 1'b0;
    if (!reset) begin
      if (bus.scan_req && !(bus.host_req && starved)) begin
        grant_scan = 1'b1;
      end else if (bus.host_req) begin
        grant_host = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.scan_ack  = 1'b0;
    bus.host_ack  = 1'b0;
    grant_addr    = '0;
    owner_d       = OWN_NONE;
    if (grant_scan) begin
      bus.mem_en   = 1'b1;
      grant_addr   = bus.scan_addr;
      bus.scan_ack = 1'b1;
      owner_d      = OWN_SCAN;
    end else if (grant_host) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.host_we;
      grant_addr    = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.host_ack  = 1'b1;
      owner_d       = bus.host_we ? OWN_NONE : OWN_HOST;
    end
  end

  assign bus.mem_addr = grant_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // RAM data lands the cycle after the access; pass it straight through on
  // the valid cycle and keep a copy so rdata holds between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_hold_q <= '0;
      host_hold_q <= '0;
    end else begin
      if (owner_q == OWN_SCAN) scan_hold_q <= bus.mem_rdata;
      if (owner_q == OWN_HOST) host_hold_q <= bus.mem_rdata;
    end
  end

  assign bus.scan_rvalid = (owner_q == OWN_SCAN);
  assign bus.host_rvalid = (owner_q == OWN_HOST);
  assign bus.scan_rdata  = bus.scan_rvalid ? bus.mem_rdata : scan_hold_q;
  assign bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : host_hold_q;

  starved_matches_cnt: assert property (@(posedge clock) disable iff (reset)
    starved == (starve_cnt == CNT_W'(STARVE_LIMIT)));

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a write-first synchronous RAM model.
module tb_vram_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  vram_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

  vram_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (8),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] ram [4096];
  initial for (int i = 0; i < 4096; i++) ram[i] = init_val(12'(i));

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  function automatic logic [41:0] all_outs();
    return {bus.host_ack, bus.host_rvalid, bus.host_rdata,
            bus.scan_ack, bus.scan_rvalid, bus.scan_rdata,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic idle_inputs();
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.scan_req = 1'b0; bus.scan_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h123; bus.host_wdata = 8'hFF;
    bus.scan_req = 1'b1; bus.scan_addr = 12'h456;
    @(negedge clock); #1;
    checks++;
    if (all_outs() !== 42'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    checks++;
    if (dut.u_starve.starve_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_starve_cnt: got %0d want 0", dut.u_starve.starve_cnt);
    end
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 42'd0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs());
    end
  endtask

  task automatic test_host_write_read();
    @(negedge clock);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h0EC; bus.host_wdata = 8'h42;
    #1;
    checks++;
    if ({bus.host_ack, bus.scan_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
        !== {4'b1011, 12'h0EC, 8'h42}) begin
      errors++; $display("FAIL hw_write_grant: got ack=%b en=%b we=%b addr=%h wd=%h want ack=1 en=1 we=1 addr=0ec wd=42",
                         bus.host_ack, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clock);
    bus.host_we = 1'b0;
    #1;
    checks++;
    if ({bus.host_ack, bus.mem_we, bus.host_rvalid} !== 3'b100) begin
      errors++; $display("FAIL hw_read_grant: got ack/we/rvalid=%b want 100",
                         {bus.host_ack, bus.mem_we, bus.host_rvalid});
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'h42}) begin
      errors++; $display("FAIL hw_read_data: got rvalid=%b rdata=%h want 1 42", bus.host_rvalid, bus.host_rdata);
    end
    checks++;
    if ({bus.scan_ack, bus.scan_rvalid, bus.scan_rdata} !== 10'd0) begin
      errors++; $display("FAIL hw_scan_quiet: got %b want 0", {bus.scan_ack, bus.scan_rvalid, bus.scan_rdata});
    end
    @(negedge clock); #1;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b0, 8'h42}) begin
      errors++; $display("FAIL hw_rdata_hold: got rvalid=%b rdata=%h want 0 42", bus.host_rvalid, bus.host_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [11:0] sa;
    logic [11:0] prev_addr;
    bit prev_scan;
    bit prev_host;
    bit exp_scan;
    bit exp_host;
    sa = '0; prev_addr = '0; prev_scan = 1'b0; prev_host = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      bus.scan_req = 1'b1; bus.scan_addr = sa;
      if (c == 0) begin
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h0A1;
      end
      if (c == 5) bus.host_req = 1'b0;
      #1;
      exp_scan = (c != 4);
      exp_host = (c == 4);
      checks++;
      if ({bus.scan_ack, bus.host_ack} !== {exp_scan, exp_host}) begin
        errors++; $display("FAIL starve_grant c%0d: got scan/host ack=%b%b want %b%b",
                           c, bus.scan_ack, bus.host_ack, exp_scan, exp_host);
      end
      checks++;
      if ({bus.scan_rvalid, bus.host_rvalid} !== {prev_scan, prev_host}) begin
        errors++; $display("FAIL starve_rvalid c%0d: got scan/host rvalid=%b%b want %b%b",
                           c, bus.scan_rvalid, bus.host_rvalid, prev_scan, prev_host);
      end
      if (prev_scan) begin
        checks++;
        if (bus.scan_rdata !== init_val(prev_addr)) begin
          errors++; $display("FAIL starve_scan_data c%0d: got %h want %h", c, bus.scan_rdata, init_val(prev_addr));
        end
      end
      if (prev_host) begin
        checks++;
        if (bus.host_rdata !== 8'hFB) begin
          errors++; $display("FAIL starve_host_data: got %h want fb", bus.host_rdata);
        end
      end
      prev_scan = exp_scan; prev_host = exp_host; prev_addr = sa;
      if (exp_scan) sa = sa + 12'd1;
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.scan_rvalid, bus.scan_rdata} !== {1'b1, init_val(12'h006)}) begin
      errors++; $display("FAIL starve_last_scan: got rvalid=%b rdata=%h want 1 %h",
                         bus.scan_rvalid, bus.scan_rdata, init_val(12'h006));
    end
  endtask

  task automatic test_return_routing();
    @(negedge clock);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h010; bus.host_wdata = 8'hAA;
    @(negedge clock);
    bus.host_addr = 12'h011; bus.host_wdata = 8'h55;
    for (int r = 0; r < 2; r++) begin
      @(negedge clock);
      idle_inputs();
      bus.scan_req = 1'b1; bus.scan_addr = 12'h010;
      #1;
      checks++;
      if ({bus.scan_ack, bus.host_ack} !== 2'b10) begin
        errors++; $display("FAIL route_scan_ack r%0d: got scan/host=%b%b want 10", r, bus.scan_ack, bus.host_ack);
      end
      @(negedge clock);
      idle_inputs();
      bus.host_req = 1'b1; bus.host_addr = 12'h011;
      #1;
      checks++;
      if ({bus.host_ack, bus.scan_rvalid, bus.host_rvalid, bus.scan_rdata} !== {3'b110, 8'hAA}) begin
        errors++; $display("FAIL route_scan_ret r%0d: got ack=%b srv=%b hrv=%b sdata=%h want 1 1 0 aa",
                           r, bus.host_ack, bus.scan_rvalid, bus.host_rvalid, bus.scan_rdata);
      end
      @(negedge clock);
      idle_inputs();
      #1;
      checks++;
      if ({bus.host_rvalid, bus.scan_rvalid, bus.host_rdata} !== {2'b10, 8'h55}) begin
        errors++; $display("FAIL route_host_ret r%0d: got hrv=%b srv=%b hdata=%h want 1 0 55",
                           r, bus.host_rvalid, bus.scan_rvalid, bus.host_rdata);
      end
    end
  endtask

  task automatic test_host_write_no_data();
    @(negedge clock);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h003; bus.host_wdata = 8'h7F;
    #1;
    checks++;
    if ({bus.host_ack, bus.mem_we, bus.mem_addr} !== {2'b11, 12'h003}) begin
      errors++; $display("FAIL wr_grant: got ack=%b we=%b addr=%h want 1 1 003", bus.host_ack, bus.mem_we, bus.mem_addr);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.mem_we, bus.host_rvalid, bus.host_rdata} !== {2'b00, 8'h55}) begin
      errors++; $display("FAIL wr_no_rvalid: got we=%b rvalid=%b rdata=%h want 0 0 55",
                         bus.mem_we, bus.host_rvalid, bus.host_rdata);
    end
    @(negedge clock);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h003;
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'h7F}) begin
      errors++; $display("FAIL wr_readback: got rvalid=%b rdata=%h want 1 7f", bus.host_rvalid, bus.host_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clock);
    bus.scan_req = 1'b1; bus.scan_addr = 12'h005;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h0EC;
    #1;
    checks++;
    if ({bus.scan_ack, bus.host_ack} !== 2'b10) begin
      errors++; $display("FAIL rst_pre_ack: got scan/host=%b%b want 10", bus.scan_ack, bus.host_ack);
    end
    @(negedge clock);
    bus.scan_req = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs() !== 42'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs());
    end
    checks++;
    if (dut.u_starve.starve_cnt !== 3'd0) begin
      errors++; $display("FAIL rst_mid_starve: got %0d want 0", dut.u_starve.starve_cnt);
    end
    @(negedge clock); #1;
    checks++;
    if (bus.scan_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_rvalid: got %b want 0", bus.scan_rvalid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.host_ack !== 1'b1) begin
      errors++; $display("FAIL rst_release_host: got %b want 1", bus.host_ack);
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata, bus.scan_rvalid} !== {1'b1, 8'h42, 1'b0}) begin
      errors++; $display("FAIL rst_release_data: got hrv=%b hdata=%h srv=%b want 1 42 0",
                         bus.host_rvalid, bus.host_rdata, bus.scan_rvalid);
    end
  endtask

  task automatic test_withdrawn();
    bit exp_host;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      bus.scan_req = 1'b1; bus.scan_addr = 12'h020;
      bus.host_we = 1'b0; bus.host_addr = 12'h030;
      bus.host_req = (c != 2);
      #1;
      exp_host = (c == 7);
      checks++;
      if ({bus.host_ack, bus.scan_ack} !== {exp_host, !exp_host}) begin
        errors++; $display("FAIL withdrawn_grant c%0d: got host/scan ack=%b%b want %b%b",
                           c, bus.host_ack, bus.scan_ack, exp_host, !exp_host);
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, init_val(12'h030)}) begin
      errors++; $display("FAIL withdrawn_data: got rvalid=%b rdata=%h want 1 %h",
                         bus.host_rvalid, bus.host_rdata, init_val(12'h030));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_host_write_read();
    test_starvation();
    test_return_routing();
    test_host_write_no_data();
    test_reset_mid_read();
    test_withdrawn();
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
